// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock divider with glitch-free ratio updates.
// Optional per-channel tick counters are enabled with CLK_GEN_EDGE_CNT_EN.
module clk_gen_multi #(
   parameter int NUM_CH        = 2,
   parameter int CNT_W         = 6,
   parameter int DEFAULT_RATIO = 5,
   parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              original_clock,
   input  logic              reset_in,
   input  logic              cfg_valid,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_ratio,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync_req,
   output logic              sync_ack,
   output logic              clock_1x,
   output logic [NUM_CH-1:0] clock_slower,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] cfg_pending
`ifdef CLK_GEN_EDGE_CNT_EN
   ,
   output logic [NUM_CH*16-1:0] edge_cnt
`endif
);

   localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEFAULT_RATIO);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic              r_clk1x;
   logic              r_ack;
   logic [NUM_CH-1:0] r_clk;
   logic [NUM_CH-1:0] r_tick;
   logic [NUM_CH-1:0] r_pend;
   logic [CNT_W-1:0]  r_cnt [NUM_CH];
   logic [CNT_W-1:0]  r_act [NUM_CH];
   logic [CNT_W-1:0]  r_shd [NUM_CH];

   logic [CNT_W-1:0]  w_ratio;
   logic              w_cfg_ok;
   logic [NUM_CH-1:0] w_wr;
   logic [NUM_CH-1:0] w_run;
   logic [NUM_CH-1:0] w_wrap;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_apply;
   logic [CNT_W-1:0]  w_shd_nxt [NUM_CH];

   assign w_ratio  = (cfg_ratio == '0) ? ONE : cfg_ratio;
   assign w_cfg_ok = cfg_valid && (int'(cfg_ch) < NUM_CH);

   // A channel keeps running until it reaches the low/zero boundary state
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_wr[i]      = w_cfg_ok && (int'(cfg_ch) == i);
         w_shd_nxt[i] = w_wr[i] ? w_ratio : r_shd[i];
         w_run[i]     = ch_en[i] || r_clk[i] || (r_cnt[i] != '0);
         w_wrap[i]    = w_run[i] && (r_cnt[i] >= r_act[i] - ONE);
         w_rise[i]    = w_wrap[i] && !r_clk[i];
         w_apply[i]   = (w_wrap[i] && r_clk[i]) || !w_run[i];
      end
   end

   always_ff @(posedge original_clock) begin
      if (reset_in) begin
         r_clk1x <= 1'b0;
         r_ack   <= 1'b0;
         r_clk   <= '0;
         r_tick  <= '0;
         r_pend  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i] <= '0;
            r_act[i] <= DEF_R;
            r_shd[i] <= DEF_R;
         end
      end else if (sync_req) begin
         r_clk1x <= 1'b0;
         r_ack   <= 1'b1;
         r_clk   <= '0;
         r_tick  <= '0;
         r_pend  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i] <= '0;
            r_act[i] <= w_shd_nxt[i];
            r_shd[i] <= w_shd_nxt[i];
         end
      end else begin
         r_clk1x <= ~r_clk1x;
         r_ack   <= 1'b0;
         r_tick  <= w_rise;
         for (int i = 0; i < NUM_CH; i++) begin
            r_shd[i] <= w_shd_nxt[i];
            if (w_apply[i]) begin
               r_act[i]  <= w_shd_nxt[i];
               r_pend[i] <= 1'b0;
            end else begin
               r_pend[i] <= r_pend[i] | w_wr[i];
            end
            if (w_wrap[i]) begin
               r_cnt[i] <= '0;
               r_clk[i] <= ~r_clk[i];
            end else if (w_run[i]) begin
               r_cnt[i] <= r_cnt[i] + ONE;
            end
         end
      end
   end

   assign sync_ack     = r_ack;
   assign clock_1x     = r_clk1x;
   assign clock_slower = r_clk;
   assign tick         = r_tick;
   assign cfg_pending  = r_pend;

`ifdef CLK_GEN_EDGE_CNT_EN
   logic [15:0] r_ecnt [NUM_CH];

   always_ff @(posedge original_clock) begin
      if (reset_in || sync_req) begin
         for (int i = 0; i < NUM_CH; i++) r_ecnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_rise[i]) r_ecnt[i] <= r_ecnt[i] + 16'd1;
         end
      end
   end

   always_comb begin
      edge_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) edge_cnt[i*16 +: 16] = r_ecnt[i];
   end
`endif

endmodule

// File: tb/tb_clk_gen_multi.sv
// Directed testbench for clk_gen_multi (two-channel DUT plus a
// three-channel DUT for out-of-range channel writes).
module tb_clk_gen_multi;

   logic       clk = 1'b0;
   logic       reset_in;
   logic       cfg_valid;
   logic [0:0] cfg_ch;
   logic [5:0] cfg_ratio;
   logic [1:0] ch_en;
   logic       sync_req;
   logic       sync_ack;
   logic       clock_1x;
   logic [1:0] clock_slower;
   logic [1:0] tick;
   logic [1:0] cfg_pending;

   logic       cfg_valid3;
   logic [1:0] cfg_ch3;
   logic       sync_ack3;
   logic       clock_1x3;
   logic [2:0] clock_slower3;
   logic [2:0] tick3;
   logic [2:0] cfg_pending3;

`ifdef CLK_GEN_EDGE_CNT_EN
   logic [31:0] edge_cnt;
   logic [47:0] edge_cnt3;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   clk_gen_multi u_dut (
      .original_clock (clk),
      .reset_in       (reset_in),
      .cfg_valid      (cfg_valid),
      .cfg_ch         (cfg_ch),
      .cfg_ratio      (cfg_ratio),
      .ch_en          (ch_en),
      .sync_req       (sync_req),
      .sync_ack       (sync_ack),
      .clock_1x       (clock_1x),
      .clock_slower   (clock_slower),
      .tick           (tick),
      .cfg_pending    (cfg_pending)
`ifdef CLK_GEN_EDGE_CNT_EN
      ,
      .edge_cnt       (edge_cnt)
`endif
   );

   clk_gen_multi #(.NUM_CH(3)) u_dut3 (
      .original_clock (clk),
      .reset_in       (reset_in),
      .cfg_valid      (cfg_valid3),
      .cfg_ch         (cfg_ch3),
      .cfg_ratio      (cfg_ratio),
      .ch_en          (3'b111),
      .sync_req       (sync_req),
      .sync_ack       (sync_ack3),
      .clock_1x       (clock_1x3),
      .clock_slower   (clock_slower3),
      .tick           (tick3),
      .cfg_pending    (cfg_pending3)
`ifdef CLK_GEN_EDGE_CNT_EN
      ,
      .edge_cnt       (edge_cnt3)
`endif
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns cycles until tick[ch] is seen, or -1 if lim cycles pass.
   task automatic wait_tick(input int ch, input int lim, output int c);
      c = -1;
      for (int k = 1; k <= lim; k++) begin
         step(1);
         if (tick[ch]) begin
            c = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset_in = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_ratio = '0;
      ch_en = 2'b11; sync_req = 1'b0; cfg_valid3 = 1'b0; cfg_ch3 = '0;
      step(3);
      n_vec++;
      if (clock_1x !== 1'b0) begin
         n_err++; $display("FAIL rst_clk1x got %b want 0", clock_1x);
      end
      n_vec++;
      if (clock_slower !== 2'b00) begin
         n_err++; $display("FAIL rst_slower got %b want 00", clock_slower);
      end
      n_vec++;
      if ({tick, sync_ack, cfg_pending} !== 5'b0) begin
         n_err++;
         $display("FAIL rst_misc got %b want 00000",
                  {tick, sync_ack, cfg_pending});
      end
   endtask

   task automatic test_defaults;
      int c;
      reset_in = 1'b0;
      wait_tick(0, 30, c);
      n_vec++;
      if (c !== 5) begin
         n_err++; $display("FAIL def_first_tick got %0d want 5", c);
      end
      n_vec++;
      if (tick !== 2'b11 || clock_1x !== 1'b1) begin
         n_err++;
         $display("FAIL def_tick_both got %b/%b want 11/1", tick, clock_1x);
      end
      step(1);
      n_vec++;
      if (tick !== 2'b00 || clock_1x !== 1'b0) begin
         n_err++;
         $display("FAIL def_tick_width got %b/%b want 00/0", tick, clock_1x);
      end
      step(4);
      n_vec++;
      if (clock_slower !== 2'b00) begin
         n_err++; $display("FAIL def_fall got %b want 00", clock_slower);
      end
      wait_tick(0, 30, c);
      n_vec++;
      if (c !== 5) begin
         n_err++; $display("FAIL def_period got %0d want 5", c);
      end
   endtask

   task automatic test_ratio_change;
      int c;
      cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_ratio = 6'd3;
      step(1);
      cfg_valid = 1'b0;
      n_vec++;
      if (cfg_pending !== 2'b01) begin
         n_err++; $display("FAIL rc_pend got %b want 01", cfg_pending);
      end
      step(3);
      n_vec++;
      if (clock_slower[0] !== 1'b1 || cfg_pending !== 2'b01) begin
         n_err++;
         $display("FAIL rc_hold got %b/%b want 1/01",
                  clock_slower[0], cfg_pending);
      end
      step(1);
      n_vec++;
      if (clock_slower[0] !== 1'b0 || cfg_pending !== 2'b00) begin
         n_err++;
         $display("FAIL rc_apply got %b/%b want 0/00",
                  clock_slower[0], cfg_pending);
      end
      wait_tick(0, 20, c);
      n_vec++;
      if (c !== 3 || clock_slower[1] !== 1'b0) begin
         n_err++;
         $display("FAIL rc_low3 got %0d/%b want 3/0", c, clock_slower[1]);
      end
      wait_tick(1, 20, c);
      n_vec++;
      if (c !== 2) begin
         n_err++; $display("FAIL rc_ch1_keep got %0d want 2", c);
      end
      wait_tick(0, 20, c);
      n_vec++;
      if (c !== 4) begin
         n_err++; $display("FAIL rc_period6 got %0d want 4", c);
      end
   endtask

   task automatic test_clamp_bypass;
      cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_ratio = 6'd0;
      step(1);
      cfg_valid = 1'b0;
      n_vec++;
      if (cfg_pending !== 2'b00 || clock_slower[1] !== 1'b0) begin
         n_err++;
         $display("FAIL cb_bypass got %b/%b want 00/0",
                  cfg_pending, clock_slower[1]);
      end
      step(1);
      n_vec++;
      if (clock_slower[1] !== 1'b1 || tick[1] !== 1'b1) begin
         n_err++;
         $display("FAIL cb_rise got %b/%b want 1/1",
                  clock_slower[1], tick[1]);
      end
      step(1);
      n_vec++;
      if (clock_slower[1] !== 1'b0 || tick[1] !== 1'b0) begin
         n_err++;
         $display("FAIL cb_fall got %b/%b want 0/0",
                  clock_slower[1], tick[1]);
      end
      step(1);
      n_vec++;
      if (clock_slower[1] !== 1'b1) begin
         n_err++; $display("FAIL cb_rise2 got %b want 1", clock_slower[1]);
      end
   endtask

   task automatic test_bad_ch;
      cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_ratio = 6'd2;
      step(1);
      n_vec++;
      if (cfg_pending3 !== 3'b000) begin
         n_err++; $display("FAIL bad_ch got %b want 000", cfg_pending3);
      end
      cfg_ch3 = 2'd2;
      step(1);
      cfg_valid3 = 1'b0;
      n_vec++;
      if (cfg_pending3 !== 3'b100) begin
         n_err++; $display("FAIL last_ch got %b want 100", cfg_pending3);
      end
      n_vec++;
      if (clock_slower[1] !== 1'b1) begin
         n_err++; $display("FAIL bc_ch1 got %b want 1", clock_slower[1]);
      end
   endtask

   task automatic test_disable;
      int c;
      int hits;
      ch_en = 2'b10;
      step(2);
      n_vec++;
      if (clock_slower[0] !== 1'b1) begin
         n_err++; $display("FAIL dis_finish got %b want 1", clock_slower[0]);
      end
      step(1);
      n_vec++;
      if (clock_slower[0] !== 1'b0) begin
         n_err++; $display("FAIL dis_fall got %b want 0", clock_slower[0]);
      end
      hits = 0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (tick[0] || clock_slower[0]) hits++;
      end
      n_vec++;
      if (hits !== 0) begin
         n_err++; $display("FAIL dis_parked got %0d want 0", hits);
      end
      ch_en = 2'b11;
      wait_tick(0, 20, c);
      n_vec++;
      if (c !== 3) begin
         n_err++; $display("FAIL dis_reen got %0d want 3", c);
      end
   endtask

   task automatic test_sync;
      int c;
      int t0;
      int t1;
      cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_ratio = 6'd4;
      step(1);
      cfg_ch = 1'b1; cfg_ratio = 6'd7;
      step(1);
      cfg_valid = 1'b0;
      n_vec++;
      if (cfg_pending !== 2'b11) begin
         n_err++; $display("FAIL sy_pend got %b want 11", cfg_pending);
      end
      sync_req = 1'b1;
      step(1);
      sync_req = 1'b0;
      n_vec++;
      if ({sync_ack, clock_1x, clock_slower, tick, cfg_pending}
          !== 8'b1000_0000) begin
         n_err++;
         $display("FAIL sy_state got %b want 10000000",
                  {sync_ack, clock_1x, clock_slower, tick, cfg_pending});
      end
      t0 = -1; t1 = -1;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         if (k == 1) begin
            n_vec++;
            if (sync_ack !== 1'b0) begin
               n_err++; $display("FAIL sy_ack_len got %b want 0", sync_ack);
            end
         end
         if (tick[0] && t0 < 0) t0 = k;
         if (tick[1] && t1 < 0) t1 = k;
      end
      n_vec++;
      if (t0 !== 4 || t1 !== 7) begin
         n_err++; $display("FAIL sy_align got %0d/%0d want 4/7", t0, t1);
      end
      sync_req = 1'b1; cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_ratio = 6'd2;
      step(1);
      sync_req = 1'b0; cfg_valid = 1'b0;
      n_vec++;
      if (sync_ack !== 1'b1 || cfg_pending !== 2'b00) begin
         n_err++;
         $display("FAIL sy_wr got %b/%b want 1/00", sync_ack, cfg_pending);
      end
`ifdef CLK_GEN_EDGE_CNT_EN
      n_vec++;
      if (edge_cnt !== 32'd0) begin
         n_err++; $display("FAIL ec_sync0 got %0h want 0", edge_cnt);
      end
`endif
      wait_tick(0, 20, c);
      n_vec++;
      if (c !== 2) begin
         n_err++; $display("FAIL sy_wr_ratio got %0d want 2", c);
      end
   endtask

`ifdef CLK_GEN_EDGE_CNT_EN
   task automatic test_edge_cnt;
      int c;
      int bad;
      bad = 0;
      for (int k = 0; k < 11; k++) begin
         wait_tick(0, 10, c);
         if (c !== 4) bad++;
      end
      n_vec++;
      if (bad !== 0 || edge_cnt[15:0] !== 16'd12) begin
         n_err++;
         $display("FAIL ec_count got %0d (bad %0d) want 12",
                  edge_cnt[15:0], bad);
      end
      n_vec++;
      if (edge_cnt[31:16] !== 16'd3) begin
         n_err++; $display("FAIL ec_ch1 got %0d want 3", edge_cnt[31:16]);
      end
      sync_req = 1'b1;
      step(1);
      sync_req = 1'b0;
      n_vec++;
      if (edge_cnt !== 32'd0) begin
         n_err++; $display("FAIL ec_clear got %0h want 0", edge_cnt);
      end
   endtask
`endif

   task automatic test_reset_mid;
      int c;
      step(3);
      reset_in = 1'b1;
      step(1);
      n_vec++;
      if ({clock_1x, clock_slower, tick, sync_ack, cfg_pending}
          !== 8'b0) begin
         n_err++;
         $display("FAIL rm_state got %b want 00000000",
                  {clock_1x, clock_slower, tick, sync_ack, cfg_pending});
      end
`ifdef CLK_GEN_EDGE_CNT_EN
      n_vec++;
      if (edge_cnt !== 32'd0) begin
         n_err++; $display("FAIL rm_ecnt got %0h want 0", edge_cnt);
      end
`endif
      reset_in = 1'b0;
      wait_tick(0, 30, c);
      n_vec++;
      if (c !== 5 || tick !== 2'b11) begin
         n_err++;
         $display("FAIL rm_default got %0d/%b want 5/11", c, tick);
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_ratio_change();
      test_clamp_bypass();
      test_bad_ch();
      test_disable();
      test_sync();
`ifdef CLK_GEN_EDGE_CNT_EN
      test_edge_cnt();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
